// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin merge of NUM_REQ write requesters onto a single FIFO write port.
// Define ARB_BURST_EN to compile in the burst-lock FSM (up to MAX_BURST back-to-back writes per grant).
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          w_full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          w_req,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_param
        $error("fifo_write_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..16");
    end

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] elig;
    logic               any_elig;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Scan downward so the candidate closest to ptr is the one left standing.
    always_comb begin
        winner   = ptr;
        cand     = ptr;
        any_elig = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (elig[cand]) begin
                winner   = cand;
                any_elig = 1'b1;
            end
        end
    end

    assign w_req = any_elig & ~w_full & w_rst;

    always_comb begin
        ack    = '0;
        w_data = '0;
        if (w_req) begin
            ack[winner] = 1'b1;
            w_data      = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            grant_id <= '0;
        end else if (w_req) begin
            grant_id <= winner;
        end
    end

`ifdef ARB_BURST_EN
    typedef enum logic {IDLE, LOCK} state_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign elig = (state == LOCK) ? (req & (NUM_REQ'(1) << owner)) : req;
    assign busy = (state == LOCK);

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A dropped owner request releases the lock even while the FIFO is full.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (w_req) begin
                    if (MAX_BURST > 1) begin
                        state_nxt = LOCK;
                        owner_nxt = winner;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        ptr_nxt = next_idx(winner);
                    end
                end
            end
            LOCK: begin
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_idx(owner);
                    cnt_nxt   = '0;
                end else if (w_req) begin
                    if (cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_idx(owner);
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign elig = req;
    assign busy = 1'b0;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            ptr <= '0;
        end else if (w_req) begin
            ptr <= next_idx(winner);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            w_clk = 1'b0;
    logic            w_rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            w_full;
    logic [N-1:0]    ack;
    logic            w_req;
    logic [DW-1:0]   w_data;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .req     (req),
        .req_data(req_data),
        .w_full  (w_full),
        .ack     (ack),
        .w_req   (w_req),
        .w_data  (w_data),
        .grant_id(grant_id),
        .busy    (busy)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] data;
        logic [1:0]    gid;
        logic          busy;
        logic          full;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: who is next in line, who holds a burst, how many writes it has made.
    int m_ptr   = 0;
    int m_gid   = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    bit m_lock  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; dir=1 replaces the model's ack with a hand-written expectation.
    task automatic cycle(input logic [N-1:0] r, input bit f, input bit rst_lo,
                         input bit dir, input logic [N-1:0] dack);
        exp_t e;
        int   win;
        bit   wr;
        @(negedge w_clk);
        req      = r;
        w_full   = f;
        w_rst    = ~rst_lo;
        req_data = $urandom;
        #2;
        e.full = f;
        if (rst_lo) begin
            m_ptr = 0; m_gid = 0; m_owner = 0; m_cnt = 0; m_lock = 1'b0;
            e.ack = '0; e.data = '0; e.gid = '0; e.busy = 1'b0;
        end else begin
            e.gid  = 2'(m_gid);
            e.busy = m_lock;
            win = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (win < 0 && r[idx] && (!m_lock || idx == m_owner)) win = idx;
            end
            wr    = (win >= 0) && !f;
            e.ack = wr ? (N'(1) << win) : '0;
            if (dir) e.ack = dack;
            e.data = '0;
            for (int i = 0; i < N; i++)
                if (e.ack[i]) e.data = req_data[i*DW +: DW];
            if (BURST && m_lock) begin
                if (!r[m_owner]) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end else if (wr) begin
                    m_cnt++;
                    m_gid = win;
                    if (m_cnt == MB) begin
                        m_lock = 1'b0;
                        m_ptr  = (m_owner + 1) % N;
                    end
                end
            end else if (wr) begin
                m_gid = win;
                if (BURST && MB > 1) begin
                    m_lock = 1'b1; m_owner = win; m_cnt = 1;
                end else begin
                    m_ptr = (win + 1) % N;
                end
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge w_clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack", ack, e.ack);
                chk("w_req", w_req, |e.ack);
                chk("w_data", w_data, e.data);
                chk("grant_id", grant_id, e.gid);
                chk("busy", busy, e.busy);
                chk("ack_onehot0", $onehot0(ack), 1);
                chk("no_ack_when_full", e.full && (ack != '0), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w_rst = 1'b0; req = '0; w_full = 1'b0; req_data = '0;
        // Reset gating with live requests
        cycle(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
        cycle(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
`ifndef ARB_BURST_EN
        // Plain rotation across all requesters
        cycle(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
        cycle(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010);
        cycle(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100);
        cycle(4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000);
        // Full stalls, then resumes from index 0
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000);
        repeat (3) cycle(4'b0101, 1'b1, 1'b0, 1'b1, 4'b0000);
        cycle(4'b0101, 1'b0, 1'b0, 1'b1, 4'b0001);
        cycle(4'b0101, 1'b0, 1'b0, 1'b1, 4'b0100);
`else
        // Two requesters each get a full burst
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000);
        repeat (4) cycle(4'b0011, 1'b0, 1'b0, 1'b1, 4'b0001);
        repeat (4) cycle(4'b0011, 1'b0, 1'b0, 1'b1, 4'b0010);
        // Owner 2 drops after two writes: one bubble, then requester 3
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000);
        cycle(4'b1100, 1'b0, 1'b0, 1'b1, 4'b0100);
        cycle(4'b1100, 1'b0, 1'b0, 1'b1, 4'b0100);
        cycle(4'b1000, 1'b0, 1'b0, 1'b1, 4'b0000);
        cycle(4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000);
`endif
        // Reset in the middle of requester 1's activity
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000);
        cycle(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010);
        cycle(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010);
        cycle(4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000);
        cycle(4'b0011, 1'b0, 1'b0, 1'b1, 4'b0001);
        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 499) == 0), 1'b0, 4'b0000);
        end
        @(negedge w_clk);
        #6;
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of write requesters sharing one FIFO write port (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning FIFO write data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning max consecutive writes per grant when burst is compiled in (1..16).
REQ-004 SHALL have port w_clk  input  1  write-domain clock, the only clock.
REQ-005 SHALL have port w_rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request, held until acked.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port w_full  input  1  FIFO full flag from the write controller.
REQ-009 SHALL have port ack  output  NUM_REQ  one-hot, write accepted this cycle.
REQ-010 SHALL have port w_req  output  1  FIFO write request.
REQ-011 SHALL have port w_data  output  DATA_WIDTH  FIFO write data.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  registered index of last requester written.
REQ-013 SHALL have port busy  output  1  high while a burst lock is held.

Function
REQ-014 SHALL compute winner combinationally: first asserted req scanning from pointer ptr upward, wrapping modulo NUM_REQ.
REQ-015 SHALL drive w_req = (any eligible req) & ~w_full, zero latency, so the FIFO samples the write on the same w_clk edge.
REQ-016 SHALL drive ack[winner] = w_req, all other ack bits 0; w_data = req_data of winner when w_req=1, else 0.
REQ-017 SHALL, when w_full=1, hold w_req=0, ack=0, and leave ptr, FSM state, burst count and grant_id unchanged.
REQ-018 SHALL update grant_id to winner on every edge where w_req=1.
REQ-019 SHALL, with burst compiled out, set ptr to (winner+1) mod NUM_REQ after every write.
REQ-020 SHALL, with burst compiled in, run FSM IDLE/LOCK: IDLE write by i with MAX_BURST>1 -> LOCK, owner=i, cnt=1.
REQ-021 SHALL, in LOCK, restrict eligibility to owner only; each owner write increments cnt.
REQ-022 SHALL, in LOCK, leave to IDLE with ptr=(owner+1) mod NUM_REQ when the write reaching cnt=MAX_BURST occurs.
REQ-023 SHALL, in LOCK, leave to IDLE with ptr=(owner+1) mod NUM_REQ, no write that cycle, when req[owner]=0, regardless of w_full.
REQ-024 SHALL hold LOCK with cnt unchanged while w_full=1 and req[owner]=1.
REQ-025 SHALL drive busy = (state==LOCK); tie busy to 0 with burst compiled out.
REQ-026 SHALL never assert more than one ack bit, and never ack while w_full=1.

Reset
REQ-027 SHALL, while w_rst=0, force ptr=0, state=IDLE, cnt=0, grant_id=0, busy=0, and gate w_req=0, ack=0, w_data=0.
REQ-028 SHALL abandon any in-progress burst on reset mid-operation; first post-reset winner scans from index 0.

Configuration
REQ-029 SHALL compile the burst-lock FSM and counter only when macro ARB_BURST_EN is defined; otherwise pure single-write round-robin per REQ-019.

Verification
REQ-030 SHALL cover: burst out, req=4'b1111, w_full=0 for 4 cycles -> ack 0001,0010,0100,1000; grant_id 0,1,2,3.
REQ-031 SHALL cover: req=4'b0101, w_full=1 for 3 cycles then 0 -> w_req=0/ack=0 during full; then ack=0001, next ack=0100.
REQ-032 SHALL cover: ARB_BURST_EN, MAX_BURST=4, req=4'b0011 steady -> ack=0001 x4, busy=1, then ack=0010 x4.
REQ-033 SHALL cover: ARB_BURST_EN, owner 2 drops req after 2 writes, req[3]=1 -> one bubble with w_req=0, busy=0, then ack=1000.
REQ-034 SHALL cover: w_rst pulsed low mid-burst (owner 1, cnt=2) -> busy=0, grant_id=0, ptr=0; after release, req=4'b0011 gives ack=0001.
REQ-035 SHALL cover: random req/w_full, 10k cycles -> ack one-hot or zero, no ack when w_full=1, w_data equals acked requester's data.
